bl_mux_sequencer: RTL and testbench
===================================

Name: bl_mux_sequencer

Overview:
- Generates the 4-bit bit-line select word {EN, A2, A1, A0} consumed by the BL_MUX decoder stage.
- Steps through a programmable range of the 8 bit-lines, one channel at a time.
- Keeps each selection open for a fixed dwell, then handshakes one sample per channel with the downstream ADC/sense logic.
- Enforces break-before-make: the address bits never change while EN is high.

Parameters:
SETTLE_CYCLES, 4, cycles with address driven and EN low before EN rises (>=1)
DWELL_CYCLES, 16, cycles EN is high before sample_req asserts (>=1)
BREAK_CYCLES, 2, cycles EN is low with address held after a sample (>=1)
CNT_W, 8, width of internal cycle counter; must hold max of the three counts

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
start  input  1  1-cycle scan request; honoured only in IDLE
ch_first  input  3  first channel; latched on accepted start
ch_last  input  3  last channel; latched on accepted start
continuous  input  1  latched on start; 1 = restart at ch_first after ch_last
abort  input  1  stop the scan; honoured in any non-IDLE state
sample_ack  input  1  sample taken; valid only while sample_req=1
control_signal  output  4  [3]=EN, [2:0]=A2..A0 to BL_MUX; registered
sample_req  output  1  request one sample on cur_ch; held until sample_ack
cur_ch  output  3  channel currently addressed (equals control_signal[2:0])
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse on normal scan completion

Behaviour:
- Reset low (asynchronous) forces: state=IDLE, control_signal=4'b0000, sample_req=0, cur_ch=0, busy=0, done=0, counter=0. All outputs are registered and change only on the rising edge of Clock when Reset is high.
- IDLE: when start=1 at edge N, the block latches ch_first, ch_last and continuous. After edge N: state=SETUP, control_signal={0,ch_first}, busy=1.
- SETUP: EN=0, address held for exactly SETTLE_CYCLES cycles, then ACTIVE.
- ACTIVE: EN=1 for exactly DWELL_CYCLES cycles, then SAMPLE.
- SAMPLE: EN stays 1 and sample_req=1 until a cycle with sample_ack=1. On that edge sample_req drops and EN drops to 0, with the address unchanged; state=BREAK.
  - If sample_ack and sample_req are high in the same cycle, the sample is accepted on that edge.
  - sample_ack is ignored in every state other than SAMPLE.
- BREAK: EN=0 and address held for BREAK_CYCLES cycles. At the end of BREAK:
  - cur_ch != latched last: cur_ch = (cur_ch+1) mod 8, then SETUP.
  - cur_ch == latched last and continuous=1: cur_ch = latched first, then SETUP.
  - cur_ch == latched last and continuous=0: control_signal=0, done=1 for one cycle, busy=0, state=IDLE.
- Wrap-around: when ch_last < ch_first the scan wraps through 7 -> 0 (for example 6,7,0,1). When ch_first == ch_last the scan covers a single channel.
- The address changes only on edges where EN is 0 both before and after the edge. EN and the address never change on the same edge.
- abort=1 in any non-IDLE state:
  - Next edge: EN=0, sample_req=0, address held, state=ABORT.
  - Following edge: control_signal=0, busy=0, state=IDLE. done is not pulsed.
  - abort has priority over sample_ack and over counter expiry in the same cycle.
  - abort in IDLE has no effect.
- start while busy is ignored.
- A simultaneous start and abort in IDLE starts the scan.
- Per-channel cycle count with an immediate ack: SETTLE + DWELL + 1 + BREAK. With the defaults this is 23 cycles.

Test Plan:
1. Reset low mid-scan (EN high on channel 3) -> control_signal=0000, sample_req=0, busy=0 asynchronously, before the next edge; after release the block stays IDLE.
2. start with first=2, last=4, continuous=0, ack returned 1 cycle after each req -> sequence 0010 (4 cycles), 1010 (16 cycles), req, 0010 (2 cycles), then channels 3 and 4 the same way; a single done pulse; busy low afterwards.
3. first=6, last=1 -> channels visited 6,7,0,1 in order; no EN=1 cycle ever coincides with an address change (checked by assertion across the whole run).
4. first=last=5, ack delayed 10 cycles -> sample_req held for 11 cycles with EN=1 throughout; exactly one sample taken; done pulse.
5. continuous=1, first=0, last=1, abort raised during SAMPLE on channel 1 together with sample_ack -> next cycle 0001 with sample_req=0; then 0000 and IDLE; no done pulse.
6. start pulsed again while busy, and sample_ack pulsed during ACTIVE -> both ignored; the channel timing is identical to scenario 2.

Source files
------------

// File: rtl/bl_mux_sequencer.sv
`default_nettype none
// ============================================================================
// Module : bl_mux_sequencer
// Brief  : Scans a channel range for the BL_MUX decoder. Each channel gets
//          settle, dwell and sample phases, then a break-before-make gap.
// Rev    : 1.0  initial release
// ============================================================================
module bl_mux_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 16,
  parameter int BREAK_CYCLES  = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] ch_first,
  input  logic [2:0] ch_last,
  input  logic       continuous,
  input  logic       abort,
  input  logic       sample_ack,
  output logic [3:0] control_signal,
  output logic       sample_req,
  output logic [2:0] cur_ch,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACTIVE = 3'd2,
    S_SAMPLE = 3'd3,
    S_BREAK  = 3'd4,
    S_ABORT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_dwell_last  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_break_last  = CNT_W'(BREAK_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_first, w_first_nxt;
  logic [2:0]       r_last, w_last_nxt;
  logic [2:0]       r_ch, w_ch_nxt;
  logic             r_cont, w_cont_nxt;
  logic             r_en, w_en_nxt;
  logic             r_req, w_req_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_first <= 3'd0;
      r_last  <= 3'd0;
      r_ch    <= 3'd0;
      r_cont  <= 1'b0;
      r_en    <= 1'b0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
      r_ch    <= w_ch_nxt;
      r_cont  <= w_cont_nxt;
      r_en    <= w_en_nxt;
      r_req   <= w_req_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Every transition that moves the address also has EN low on both sides.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_first_nxt = r_first;
    w_last_nxt  = r_last;
    w_ch_nxt    = r_ch;
    w_cont_nxt  = r_cont;
    w_en_nxt    = r_en;
    w_req_nxt   = r_req;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    if (abort && r_state != S_IDLE && r_state != S_ABORT) begin
      w_state_nxt = S_ABORT;
      w_cnt_nxt   = '0;
      w_en_nxt    = 1'b0;
      w_req_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (start) begin
            w_first_nxt = ch_first;
            w_last_nxt  = ch_last;
            w_cont_nxt  = continuous;
            w_ch_nxt    = ch_first;
            w_en_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == c_settle_last) begin
            w_cnt_nxt   = '0;
            w_en_nxt    = 1'b1;
            w_state_nxt = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (r_cnt == c_dwell_last) begin
            w_cnt_nxt   = '0;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          w_cnt_nxt = r_cnt;
          if (sample_ack) begin
            w_cnt_nxt   = '0;
            w_req_nxt   = 1'b0;
            w_en_nxt    = 1'b0;
            w_state_nxt = S_BREAK;
          end
        end
        S_BREAK: begin
          if (r_cnt == c_break_last) begin
            w_cnt_nxt = '0;
            if (r_ch != r_last) begin
              w_ch_nxt    = r_ch + 3'd1;
              w_state_nxt = S_SETUP;
            end else if (r_cont) begin
              w_ch_nxt    = r_first;
              w_state_nxt = S_SETUP;
            end else begin
              w_ch_nxt    = 3'd0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_ABORT: begin
          w_cnt_nxt   = '0;
          w_ch_nxt    = 3'd0;
          w_en_nxt    = 1'b0;
          w_req_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_cnt_nxt   = '0;
          w_ch_nxt    = 3'd0;
          w_en_nxt    = 1'b0;
          w_req_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign control_signal = {r_en, r_ch};
  assign cur_ch         = r_ch;
  assign sample_req     = r_req;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bl_mux_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_bl_mux_sequencer
// Brief  : Directed self-checking bench for bl_mux_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bl_mux_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] ch_first;
  logic [2:0] ch_last;
  logic       continuous;
  logic       abort;
  logic       sample_ack;
  logic [3:0] control_signal;
  logic       sample_req;
  logic [2:0] cur_ch;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  bl_mux_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .ch_first       (ch_first),
    .ch_last        (ch_last),
    .continuous     (continuous),
    .abort          (abort),
    .sample_ack     (sample_ack),
    .control_signal (control_signal),
    .sample_req     (sample_req),
    .cur_ch         (cur_ch),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {EN, A2..A0, sample_req, busy, done}
  function automatic logic [6:0] obs();
    return {control_signal, sample_req, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [6:0] o, input logic [6:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge that moved into SETUP for channel ch.
  task automatic run_channel(input logic [2:0] ch, input int ack_delay,
                             input bit inject, input bit abort_in_sample);
    for (int i = 0; i < 4; i++) begin
      chk("setup", obs(), {1'b0, ch, 3'b010});
      if (inject && i == 1) begin
        start    = 1'b1;
        ch_first = 3'd7;
      end
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      chk("active", obs(), {1'b1, ch, 3'b010});
      if (inject && i == 5) sample_ack = 1'b1;
      step();
      sample_ack = 1'b0;
    end
    for (int i = 0; i < ack_delay; i++) begin
      chk("sample_wait", obs(), {1'b1, ch, 3'b110});
      step();
    end
    chk("sample", obs(), {1'b1, ch, 3'b110});
    sample_ack = 1'b1;
    if (abort_in_sample) abort = 1'b1;
    step();
    sample_ack = 1'b0;
    abort      = 1'b0;
    if (abort_in_sample) begin
      chk("abort_hold", obs(), {1'b0, ch, 3'b010});
      step();
      chk("abort_idle", obs(), 7'b0000000);
      step();
      chk("abort_nodone", obs(), 7'b0000000);
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk("break", obs(), {1'b0, ch, 3'b010});
        step();
      end
    end
  endtask

  // Break-before-make: any address move must have EN low before and after.
  logic [3:0] prev_ctrl;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ctrl <= control_signal;
    end else begin
      if (control_signal[2:0] != prev_ctrl[2:0]) begin
        checks++;
        assert (!prev_ctrl[3] && !control_signal[3] && cur_ch == control_signal[2:0]) else begin
          errors++;
          $error("FAIL bbm: observed %b->%b expected EN low across address move",
                 prev_ctrl, control_signal);
        end
      end
      prev_ctrl <= control_signal;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    ch_first   = 3'd0;
    ch_last    = 3'd0;
    continuous = 1'b0;
    abort      = 1'b0;
    sample_ack = 1'b0;
    step();
    step();
    chk("reset", obs(), 7'b0000000);
    rst_n = 1'b1;
    step();
    chk("idle", obs(), 7'b0000000);

    // Asynchronous reset while EN is high on channel 3
    start    = 1'b1;
    ch_first = 3'd3;
    ch_last  = 3'd3;
    step();
    start = 1'b0;
    chk("t1_setup", obs(), 7'b0011010);
    repeat (5) step();
    chk("t1_active", obs(), 7'b1011010);
    #2 rst_n = 1'b0;
    #1 chk("t1_async_reset", obs(), 7'b0000000);
    step();
    rst_n = 1'b1;
    step();
    chk("t1_idle_a", obs(), 7'b0000000);
    step();
    chk("t1_idle_b", obs(), 7'b0000000);

    // Plain scan 2..4
    start      = 1'b1;
    ch_first   = 3'd2;
    ch_last    = 3'd4;
    continuous = 1'b0;
    step();
    start = 1'b0;
    run_channel(3'd2, 0, 1'b0, 1'b0);
    run_channel(3'd3, 0, 1'b0, 1'b0);
    run_channel(3'd4, 0, 1'b0, 1'b0);
    chk("t2_done", obs(), 7'b0000001);
    step();
    chk("t2_after", obs(), 7'b0000000);

    // Wrap-around scan 6..1
    start    = 1'b1;
    ch_first = 3'd6;
    ch_last  = 3'd1;
    step();
    start = 1'b0;
    run_channel(3'd6, 0, 1'b0, 1'b0);
    run_channel(3'd7, 0, 1'b0, 1'b0);
    run_channel(3'd0, 0, 1'b0, 1'b0);
    run_channel(3'd1, 0, 1'b0, 1'b0);
    chk("t3_done", obs(), 7'b0000001);
    step();
    chk("t3_after", obs(), 7'b0000000);

    // abort alone in IDLE does nothing
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort", obs(), 7'b0000000);

    // Single channel 5, delayed ack; start together with abort in IDLE
    start    = 1'b1;
    abort    = 1'b1;
    ch_first = 3'd5;
    ch_last  = 3'd5;
    step();
    start = 1'b0;
    abort = 1'b0;
    run_channel(3'd5, 10, 1'b0, 1'b0);
    chk("t4_done", obs(), 7'b0000001);
    step();
    chk("t4_after", obs(), 7'b0000000);

    // Continuous 0..1, aborted in SAMPLE together with ack
    start      = 1'b1;
    ch_first   = 3'd0;
    ch_last    = 3'd1;
    continuous = 1'b1;
    step();
    start      = 1'b0;
    continuous = 1'b0;
    run_channel(3'd0, 0, 1'b0, 1'b0);
    run_channel(3'd1, 0, 1'b0, 1'b0);
    run_channel(3'd0, 0, 1'b0, 1'b0);
    run_channel(3'd1, 0, 1'b0, 1'b1);

    // Scan 2..4 again with stray start and ack while busy
    start    = 1'b1;
    ch_first = 3'd2;
    ch_last  = 3'd4;
    step();
    start = 1'b0;
    run_channel(3'd2, 0, 1'b1, 1'b0);
    run_channel(3'd3, 0, 1'b1, 1'b0);
    run_channel(3'd4, 0, 1'b1, 1'b0);
    chk("t6_done", obs(), 7'b0000001);
    step();
    chk("t6_after", obs(), 7'b0000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
